// File: rtl/sram_controller_if.sv
// sram_controller_if: pipeline-side MEM-stage request/response bundle.
interface sram_controller_if;
  logic rdEn;
  logic wrEn;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic ready;
  modport master(output rdEn, wrEn, address, writeData, input readData, ready);
  modport slave(input rdEn, wrEn, address, writeData, output readData, ready);
endinterface

// File: rtl/sram_controller.sv
// sram_controller: splits a 32-bit MEM access into two timed 16-bit async SRAM phases, freezing the pipeline meanwhile.
module sram_controller #(
  parameter int BASE_ADDR = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rest,
  sram_controller_if.slave bus,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic SRAM_WE_N,
  output logic SRAM_OE_N,
  output logic SRAM_CE_N,
  output logic SRAM_UB_N,
  output logic SRAM_LB_N
);
  localparam int CW = $clog2(WAIT_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic op_wr, drive, req, last;
  logic [15:0] dq_out;
  logic [16:0] widx;
  logic [31:0] read_data;
  assign req = bus.rdEn | bus.wrEn;
  assign widx = 17'((bus.address - 32'(BASE_ADDR)) >> 2);
  assign last = cnt == CW'(WAIT_CYCLES - 1);
  assign bus.ready = (state == IDLE && !req) || state == DONE;
  assign bus.readData = read_data;
  assign SRAM_DQ = drive ? dq_out : 'z;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  // Bus outputs are set on the edge entering each phase so they are glitch-free registers.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state <= IDLE;
      cnt <= '0;
      op_wr <= 1'b0;
      drive <= 1'b0;
      dq_out <= '0;
      read_data <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
    end else begin
      case (state)
        IDLE: if (req) begin
          state <= LO;
          cnt <= '0;
          op_wr <= bus.wrEn;
          drive <= bus.wrEn;
          dq_out <= bus.writeData[15:0];
          SRAM_ADDR <= {widx, 1'b0};
          SRAM_WE_N <= !bus.wrEn;
        end
        LO: if (last) begin
          state <= HI;
          cnt <= '0;
          dq_out <= bus.writeData[31:16];
          SRAM_ADDR <= {widx, 1'b1};
          if (!op_wr) read_data[15:0] <= SRAM_DQ;
        end else cnt <= cnt + 1'b1;
        HI: if (last) begin
          state <= DONE;
          cnt <= '0;
          drive <= 1'b0;
          SRAM_ADDR <= '0;
          SRAM_WE_N <= 1'b1;
          if (!op_wr) read_data[31:16] <= SRAM_DQ;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: table-driven accesses on WAIT=2 and WAIT=1 instances against behavioural SRAMs.
module tb_sram_controller;
  logic clk = 0, rest = 0;
  always #5 clk = ~clk;
  sram_controller_if if_a();
  sram_controller_if if_b();
  wire [15:0] dq_a, dq_b;
  logic [17:0] sa_a, sa_b;
  logic we_a, we_b, oe_a, ce_a, ub_a, lb_a, oe_b, ce_b, ub_b, lb_b;
  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(2)) dut_a (.clk(clk), .rest(rest), .bus(if_a), .SRAM_DQ(dq_a),
    .SRAM_ADDR(sa_a), .SRAM_WE_N(we_a), .SRAM_OE_N(oe_a), .SRAM_CE_N(ce_a), .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a));
  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(1)) dut_b (.clk(clk), .rest(rest), .bus(if_b), .SRAM_DQ(dq_b),
    .SRAM_ADDR(sa_b), .SRAM_WE_N(we_b), .SRAM_OE_N(oe_b), .SRAM_CE_N(ce_b), .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b));
  logic [15:0] mem_a [0:262143];
  logic [15:0] mem_b [0:262143];
  assign dq_a = we_a ? mem_a[sa_a] : 'z;
  assign dq_b = we_b ? mem_b[sa_b] : 'z;
  always @(posedge clk) begin
    if (!we_a) mem_a[sa_a] <= dq_a;
    if (!we_b) mem_b[sa_b] <= dq_b;
  end
  logic rd_i [2], wr_i [2], rdy [2], we [2];
  logic [31:0] ad_i [2], wd_i [2], rdd [2];
  logic [17:0] sa [2];
  logic [15:0] dqv [2];
  assign if_a.rdEn = rd_i[0];
  assign if_a.wrEn = wr_i[0];
  assign if_a.address = ad_i[0];
  assign if_a.writeData = wd_i[0];
  assign if_b.rdEn = rd_i[1];
  assign if_b.wrEn = wr_i[1];
  assign if_b.address = ad_i[1];
  assign if_b.writeData = wd_i[1];
  assign rdy[0] = if_a.ready;
  assign rdy[1] = if_b.ready;
  assign rdd[0] = if_a.readData;
  assign rdd[1] = if_b.readData;
  assign sa[0] = sa_a;
  assign sa[1] = sa_b;
  assign we[0] = we_a;
  assign we[1] = we_b;
  assign dqv[0] = dq_a;
  assign dqv[1] = dq_b;
  typedef struct {
    int sel;
    bit rd, wr, b2b;
    logic [31:0] addr, wdata;
    logic [17:0] lo;
  } vec_t;
  vec_t vecs [$];
  logic [31:0] ref_mem [int];
  logic [31:0] sb [$];
  int n_cmp = 0, n_fail = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic access(vec_t v);
    int w = v.sel ? 1 : 2;
    int key = v.sel * 262144 + int'(v.lo);
    logic [31:0] exp;
    bit lo, hi;
    rd_i[v.sel] = v.rd;
    wr_i[v.sel] = v.wr;
    ad_i[v.sel] = v.addr;
    wd_i[v.sel] = v.wdata;
    if (v.wr) ref_mem[key] = v.wdata;
    else sb.push_back(ref_mem.exists(key) ? ref_mem[key] : 32'h0);
    exp = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
    for (int c = 0; c <= 2 * w + 1; c++) begin
      @(negedge clk);
      lo = c >= 1 && c <= w;
      hi = c > w && c <= 2 * w;
      chk("ready", 32'(rdy[v.sel]), 32'(c == 2 * w + 1));
      chk("sram_addr", 32'(sa[v.sel]), lo ? 32'(v.lo) : hi ? 32'(v.lo | 18'h1) : 32'h0);
      chk("we_n", 32'(we[v.sel]), 32'(!(v.wr && (lo || hi))));
      if (lo || hi) chk("dq", 32'(dqv[v.sel]), hi ? 32'(exp[31:16]) : 32'(exp[15:0]));
      if (c == 2 * w + 1 && !v.wr) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rdata: got %h want <empty scoreboard>", rdd[v.sel]);
        end else chk("rdata", rdd[v.sel], sb.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (!v.b2b) begin
      rd_i[v.sel] = 0;
      wr_i[v.sel] = 0;
      @(negedge clk);
      chk("idle_ready", 32'(rdy[v.sel]), 32'h1);
      chk("idle_addr", 32'(sa[v.sel]), 32'h0);
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    foreach (rd_i[i]) begin
      rd_i[i] = 0;
      wr_i[i] = 0;
      ad_i[i] = 0;
      wd_i[i] = 0;
    end
    vecs.push_back('{0, 0, 1, 0, 32'd1024, 32'hDEADBEEF, 18'h0});
    vecs.push_back('{0, 1, 0, 0, 32'd1024, 32'h0, 18'h0});
    vecs.push_back('{0, 0, 1, 0, 32'h000803FF, 32'hCAFEF00D, 18'h3FFFE});
    vecs.push_back('{0, 1, 0, 0, 32'd1020, 32'h0, 18'h3FFFE});
    vecs.push_back('{0, 0, 1, 1, 32'd1028, 32'h12345678, 18'h2});
    vecs.push_back('{0, 1, 0, 0, 32'd1028, 32'h0, 18'h2});
    vecs.push_back('{0, 1, 1, 0, 32'd1032, 32'hA5A55A5A, 18'h4});
    vecs.push_back('{0, 1, 0, 0, 32'd1032, 32'h0, 18'h4});
    vecs.push_back('{1, 0, 1, 0, 32'd1040, 32'h0BADCAFE, 18'h8});
    vecs.push_back('{1, 1, 0, 1, 32'd1040, 32'h0, 18'h8});
    vecs.push_back('{1, 1, 0, 0, 32'd1040, 32'h0, 18'h8});
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", 32'(rdy[s]), 32'h1);
      chk("rst_we_n", 32'(we[s]), 32'h1);
      chk("rst_addr", 32'(sa[s]), 32'h0);
      chk("rst_rdata", rdd[s], 32'h0);
    end
    rest = 1;
    @(posedge clk);
    #1;
    foreach (vecs[i]) access(vecs[i]);
    rd_i[0] = 0;
    wr_i[0] = 1;
    ad_i[0] = 1036;
    wd_i[0] = 32'h11112222;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midlo_we_n", 32'(we[0]), 32'h0);
    #1 rest = 0;
    #1;
    chk("async_we_n", 32'(we[0]), 32'h1);
    chk("async_addr", 32'(sa[0]), 32'h0);
    chk("async_ready_req", 32'(rdy[0]), 32'h0);
    wr_i[0] = 0;
    #1;
    chk("async_ready_idle", 32'(rdy[0]), 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("rst_rdata_a", rdd[0], 32'h0);
    chk("rst_rdata_b", rdd[1], 32'h0);
    rest = 1;
    @(posedge clk);
    #1;
    access('{0, 1, 0, 0, 32'd1028, 32'h0, 18'h2});
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sequences the MEM-stage data memory access generated from the EXE stage's memory command (ALU result address, Rm value, MEM_R_EN/MEM_W_EN) onto an off-chip 16-bit asynchronous SRAM.
- Each 32-bit word is split into two 16-bit half-word phases, each lasting a fixed number of cycles.
- Drives ready low so the pipeline freezes until the access completes.

Parameters:
- BASE_ADDR, 1024: byte address of SRAM word 0; subtracted from the incoming address.
- WAIT_CYCLES, 2: cycles per half-word phase, ≥1.

Ports:
- clk  input  1  system clock, rising edge
- rest  input  1  asynchronous, active-low reset
- rdEn  input  1  memory read request, held stable while ready=0
- wrEn  input  1  memory write request, held stable while ready=0
- address  input  32  byte address (ALU result)
- writeData  input  32  store data (Rm value)
- readData  output  32  load data, registered
- ready  output  1  1 = no access pending or access completes this cycle; 0 = freeze pipeline
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  output  18  SRAM half-word address
- SRAM_WE_N  output  1  SRAM write enable, active low
- SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  tied 0

Behaviour:
- Word index: wIdx = (address - BASE_ADDR)[18:2], 17 bits, modulo arithmetic.
  - Addresses below BASE wrap; bits [1:0] and above [18] are ignored.
  - Half address: LO phase = {wIdx,0}, HI phase = {wIdx,1}.
- Request: req = rdEn | wrEn. If both are set, the access is a write.
- States: IDLE, LO, HI, DONE; one counter of width clog2(WAIT_CYCLES)+1.
  - IDLE: ready = ~req (combinational). If req, latch op (read/write) → LO, counter = 0.
  - LO: ready=0; SRAM_ADDR={wIdx,0}. Count WAIT_CYCLES cycles, then → HI.
    - Read: on the clock edge ending the last LO cycle, capture readData[15:0] ← SRAM_DQ.
  - HI: ready=0; SRAM_ADDR={wIdx,1}. Count WAIT_CYCLES cycles, then → DONE.
    - Read: on the clock edge ending the last HI cycle, capture readData[31:16].
  - DONE: ready=1 for exactly one cycle → IDLE unconditionally. The pipeline advances on this edge.
- Latency: request first seen in cycle 0 → ready=1 in cycle 2·WAIT_CYCLES+1 (cycle 5 at default). The request is held for 2·WAIT_CYCLES+2 cycles.
- Back-to-back: a new request in the IDLE cycle after DONE starts immediately; there are no dead cycles beyond the IDLE decision cycle.
- Write drive:
  - SRAM_WE_N = 0 during all LO/HI cycles of a write, 1 otherwise.
  - SRAM_DQ = writeData[15:0] in LO and writeData[31:16] in HI of a write; high-Z in all other states and during reads.
  - Writes never modify readData.
- Idle bus: SRAM_ADDR = 0 in IDLE and DONE.
- readData holds its value until the next read's captures. The low half updates first, so it is only guaranteed coherent while ready=1 in DONE.
- Request dropped mid-access (illegal): the FSM completes the latched operation regardless.
- Reset (rest=0), asynchronous, including mid-access:
  - state=IDLE, counter=0, readData=0, SRAM_WE_N=1, SRAM_DQ=Z, SRAM_ADDR=0.
  - ready follows IDLE rule (1 if no request).
  - A write interrupted by reset may leave a partial half-word in SRAM; this is accepted.

Test Plan:
- Reset, no request → ready=1, SRAM_WE_N=1, DQ=Z, readData=0. Assert rest=0 for one cycle mid-LO of a write → WE_N=1 and state IDLE immediately, before the next clock edge.
- Write wrEn, address=1024, writeData=0xDEADBEEF, WAIT=2:
  - ready=0 cycles 0–4, ready=1 cycle 5.
  - SRAM_ADDR=0 with DQ=0xBEEF, WE_N=0 in cycles 1–2.
  - SRAM_ADDR=1 with DQ=0xDEAD in cycles 3–4.
- Read rdEn, address=1024 after the above, SRAM model returns stored halves → readData=0xDEADBEEF in cycle 5 with ready=1. DQ stays Z from the controller throughout and WE_N=1.
- Address mapping: address=1024+4·0x1FFFF+3 → SRAM_ADDR 0x3FFFE (LO) / 0x3FFFF (HI). Address=1020 → wIdx=0x1FFFF (wrap).
- Back-to-back: write 0x12345678 to address 1028, then a read of 1028 presented in the cycle after DONE → read starts with no extra idle cycle and returns 0x12345678. Also rdEn=wrEn=1 is treated as a write.
- WAIT_CYCLES=1 instance: single read → ready=1 in cycle 3. Each phase lasts exactly 1 cycle.
